test_pattern_gen: RTL and testbench
===================================

// Module: test_pattern_gen
// PURPOSE
//  Parametrised AXI-Stream test source that feeds the OSPFB datapath ahead of the
//  phase/pause counter. It generates impulse, DC, ramp or swept-impulse frames of
//  run-time length, with full tvalid/tready backpressure and a registered output.
//  A frame count and start/done handshake let benches run a bounded number of frames.
// PARAMETERS
//  WIDTH        16   tdata width, in bits
//  MAX_PERIOD   64   largest frame length supported; sets CW=$clog2(MAX_PERIOD)
//  FRAME_W      16   width of the frame counter and of cfg_nframes
// PORTS
//  clk            in   1        clock
//  rst            in   1        synchronous, active-high reset
//  start          in   1        pulse: leave IDLE/DONE and begin generating
//  cfg_mode       in   2        0=impulse 1=DC 2=ramp 3=swept impulse
//  cfg_period     in   CW+1     frame length P, valid range 1..MAX_PERIOD
//  cfg_phase      in   CW+1     impulse position within the frame
//  cfg_val        in   WIDTH    impulse/DC amplitude
//  cfg_nframes    in   FRAME_W  frames to emit; 0 = run until reset
//  m_axis_tdata   out  WIDTH    sample
//  m_axis_tvalid  out  1        sample valid
//  m_axis_tready  in   1        downstream ready
//  m_axis_tlast   out  1        high on the last sample of each frame
//  busy           out  1        high in RUN
//  done           out  1        high in DONE
// BEHAVIOUR
//  - Reset: state=IDLE, tvalid=0, tdata=0, tlast=0, busy=0, done=0. Internal
//    counters ctr, frame and sweep are all cleared.
//  - FSM: IDLE --start--> RUN; RUN --last beat of frame cfg_nframes-1 accepted--> DONE;
//    DONE --start--> RUN. A start pulse while in RUN is ignored.
//  - Config is sampled into shadow registers on start and again at every frame
//    boundary, i.e. when the tlast beat is accepted. A config change mid-frame
//    therefore takes effect on the next frame only.
//  - Latency: start at edge t gives tvalid=1 after edge t+1, carrying sample ctr=0.
//  - Handshake: a beat is accepted when tvalid&&tready.
//      * tdata and tlast update only when (!tvalid || tready).
//      * While tvalid && !tready, tdata and tlast hold stable.
//      * tvalid never drops without an accepted beat, except on reset.
//  - ctr counts 0..P-1 and advances per accepted beat, wrapping P-1 -> 0.
//    tlast = (ctr==P-1).
//  - Sample value by mode:
//      * impulse: cfg_val when ctr==cfg_phase, else 0.
//      * DC: cfg_val on every beat.
//      * ramp: ctr, zero-extended to WIDTH.
//      * swept: cfg_val when ctr==(cfg_phase+sweep) mod P, else 0. sweep increments
//        at each frame boundary and wraps P-1 -> 0.
//  - cfg_phase >= P in impulse or swept mode: the frame is all zeros, with no error flag.
//  - cfg_period=0 is treated as P=1. cfg_period>MAX_PERIOD is clamped to MAX_PERIOD.
//  - P=1: every beat has tlast=1 and every beat is a frame boundary.
//  - Leaving RUN:
//      * After the final accepted beat, tvalid=0 on the next cycle and done=1 until start.
//      * Restarting from DONE clears ctr, frame and sweep.
//      * cfg_nframes=0 never reaches DONE; frame wraps silently.
//  - Reset mid-frame: all outputs return to reset values on the next edge; no partial frame resumes.
//  - Simultaneous start and rst: rst wins.
// TESTING
//  1. Impulse, P=64, phase=49, val=1, nframes=4, tready=1 -> 256 beats; tdata=1 only at
//     beat index 49 of each frame; tlast at indices 63,127,191,255; then done=1.
//  2. Random tready (50%), same config -> accepted beat stream identical to scenario 1;
//     tdata/tlast never change while tvalid&&!tready.
//  3. Swept, P=8, phase=0, val=5, nframes=8 -> frame k carries 5 at index k; frame 7 at index 7.
//  4. Ramp, P=16 -> tdata 0..15 repeating; DC val=0x7FFF -> every beat 0x7FFF.
//  5. phase changed 10->20 at beat 5 of frame 0 (P=32) -> impulse at 10 in frame 0,
//     at 20 in frame 1.
//  6. rst asserted at beat 30 of frame 1 -> tvalid=0 next cycle; restart after start
//     -> first beat is ctr=0, frame 0.

Source files
------------

// File: rtl/test_pattern_gen.sv
// test_pattern_gen: AXI-Stream test source producing impulse, DC, ramp or
// swept-impulse frames of run-time length with a registered output stage.
// Config is shadowed on start and on every accepted tlast beat, so a mid-frame
// config change only affects the following frame.
module test_pattern_gen #(
    parameter int WIDTH      = 16,
    parameter int MAX_PERIOD = 64,
    parameter int FRAME_W    = 16,
    localparam int CW        = $clog2(MAX_PERIOD),
    localparam int PW        = CW + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         cfg_mode,
    input  logic [PW-1:0]      cfg_period,
    input  logic [PW-1:0]      cfg_phase,
    input  logic [WIDTH-1:0]   cfg_val,
    input  logic [FRAME_W-1:0] cfg_nframes,
    output logic [WIDTH-1:0]   m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] MODE_IMP  = 2'd0;
    localparam logic [1:0] MODE_DC   = 2'd1;
    localparam logic [1:0] MODE_RAMP = 2'd2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nxt;

    // Shadowed config; sh_p always holds the effective period 1..MAX_PERIOD
    logic [1:0]         sh_mode;
    logic [PW-1:0]      sh_p;
    logic [PW-1:0]      sh_phase;
    logic [WIDTH-1:0]   sh_val;
    logic [FRAME_W-1:0] sh_nframes;

    // ctr is the in-frame index of the beat sitting in (or about to enter) the output register
    logic [PW-1:0]      ctr;
    logic [FRAME_W-1:0] frame;
    logic [PW-1:0]      sweep;

    logic               start_go, accept, boundary, final_beat;
    logic [1:0]         nx_mode;
    logic [PW-1:0]      nx_p, nx_phase, nx_ctr, nx_sweep, sw_inc;
    logic [WIDTH-1:0]   nx_val, cur_smp, nxt_smp;
    logic [FRAME_W-1:0] nx_nframes, nx_frame;

    // Period 0 behaves as 1, anything past MAX_PERIOD saturates
    function automatic logic [PW-1:0] clamp_period(input logic [PW-1:0] p);
        if (p == '0)
            return PW'(1);
        if (p > PW'(MAX_PERIOD))
            return PW'(MAX_PERIOD);
        return p;
    endfunction

    // Sample value for index c; swept position is (phase+sw) mod p, and since
    // phase<p and sw<p one conditional subtract replaces the modulo
    function automatic logic [WIDTH-1:0] sample(input logic [1:0] mode, input logic [PW-1:0] p,
                                                input logic [PW-1:0] phase, input logic [WIDTH-1:0] val,
                                                input logic [PW-1:0] c, input logic [PW-1:0] sw);
        logic [PW:0]      pos;
        logic [WIDTH-1:0] s;
        s   = '0;
        pos = {1'b0, phase} + {1'b0, sw};
        if (pos >= {1'b0, p})
            pos = pos - {1'b0, p};
        case (mode)
            MODE_IMP:  if (c == phase) s = val;
            MODE_DC:   s = val;
            MODE_RAMP: s = WIDTH'(c);
            default:   if ((phase < p) && ({1'b0, c} == pos)) s = val;
        endcase
        return s;
    endfunction

    // Handshake decode and next-beat config/counter selection
    always_comb begin
        start_go   = start && (state != RUN);
        accept     = m_axis_tvalid && m_axis_tready;
        boundary   = accept && m_axis_tlast;
        final_beat = boundary && (sh_nframes != '0) && (frame == sh_nframes - FRAME_W'(1));

        nx_mode    = boundary ? cfg_mode               : sh_mode;
        nx_p       = boundary ? clamp_period(cfg_period) : sh_p;
        nx_phase   = boundary ? cfg_phase              : sh_phase;
        nx_val     = boundary ? cfg_val                : sh_val;
        nx_nframes = boundary ? cfg_nframes            : sh_nframes;

        nx_ctr     = boundary ? '0 : ctr + PW'(1);
        nx_frame   = boundary ? frame + FRAME_W'(1) : frame;
        sw_inc     = sweep + PW'(1);
        nx_sweep   = sweep;
        if (boundary)
            nx_sweep = (sw_inc >= nx_p) ? '0 : sw_inc;

        cur_smp    = sample(sh_mode, sh_p, sh_phase, sh_val, ctr, sweep);
        nxt_smp    = sample(nx_mode, nx_p, nx_phase, nx_val, nx_ctr, nx_sweep);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (final_beat)
                    state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start)
                    state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow config, counters and the registered output beat
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_mode       <= '0;
            sh_p          <= PW'(1);
            sh_phase      <= '0;
            sh_val        <= '0;
            sh_nframes    <= '0;
            ctr           <= '0;
            frame         <= '0;
            sweep         <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (start_go) begin
            sh_mode       <= cfg_mode;
            sh_p          <= clamp_period(cfg_period);
            sh_phase      <= cfg_phase;
            sh_val        <= cfg_val;
            sh_nframes    <= cfg_nframes;
            ctr           <= '0;
            frame         <= '0;
            sweep         <= '0;
            m_axis_tvalid <= 1'b0;
        end else if (state == RUN) begin
            if (!m_axis_tvalid) begin
                // first beat after start: fill the empty output register
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= cur_smp;
                m_axis_tlast  <= (ctr == sh_p - PW'(1));
            end else if (m_axis_tready) begin
                if (final_beat) begin
                    m_axis_tvalid <= 1'b0;
                    m_axis_tdata  <= '0;
                    m_axis_tlast  <= 1'b0;
                end else begin
                    sh_mode       <= nx_mode;
                    sh_p          <= nx_p;
                    sh_phase      <= nx_phase;
                    sh_val        <= nx_val;
                    sh_nframes    <= nx_nframes;
                    ctr           <= nx_ctr;
                    frame         <= nx_frame;
                    sweep         <= nx_sweep;
                    m_axis_tdata  <= nxt_smp;
                    m_axis_tlast  <= (nx_ctr == nx_p - PW'(1));
                end
            end
        end
    end

endmodule

// File: tb/tb_test_pattern_gen.sv
// tb_test_pattern_gen: randomized-backpressure bench for test_pattern_gen with a
// frame-level reference model (index/frame arithmetic, modulo sweep).
module tb_test_pattern_gen;

    localparam int WIDTH      = 16;
    localparam int MAX_PERIOD = 64;
    localparam int FRAME_W    = 16;
    localparam int PW         = $clog2(MAX_PERIOD) + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [1:0]         cfg_mode;
    logic [PW-1:0]      cfg_period;
    logic [PW-1:0]      cfg_phase;
    logic [WIDTH-1:0]   cfg_val;
    logic [FRAME_W-1:0] cfg_nframes;
    logic [WIDTH-1:0]   m_axis_tdata;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic               m_axis_tlast;
    logic               busy;
    logic               done;

    int n_checks = 0;
    int n_pass   = 0;
    int ready_pct = 100;
    int stall_viol = 0;

    logic [WIDTH:0] got[$];
    logic [WIDTH:0] exp_q[$];
    logic           prev_stall = 1'b0;
    logic           prev_rst   = 1'b1;
    logic [WIDTH:0] prev_beat  = '0;

    test_pattern_gen #(.WIDTH(WIDTH), .MAX_PERIOD(MAX_PERIOD), .FRAME_W(FRAME_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_phase(cfg_phase),
        .cfg_val(cfg_val), .cfg_nframes(cfg_nframes),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // downstream ready, re-rolled each cycle just after the active edge
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = ($urandom_range(99) < ready_pct);
        end
    end

    // record accepted beats; flag any change of a stalled beat
    always @(negedge clk) begin
        if (prev_stall && !prev_rst && !rst)
            if (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} !== prev_beat)
                stall_viol++;
        if (m_axis_tvalid && m_axis_tready)
            got.push_back({m_axis_tlast, m_axis_tdata});
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_beat  = {m_axis_tlast, m_axis_tdata};
        prev_rst   = rst;
    end

    function automatic int eff_p(input int period);
        if (period == 0) return 1;
        if (period > MAX_PERIOD) return MAX_PERIOD;
        return period;
    endfunction

    // expected beat i of frame k with a fixed config
    function automatic logic [WIDTH:0] model_beat(input int mode, input int p, input int phase,
                                                  input int val, input int k, input int i);
        int d;
        case (mode)
            0:       d = (i == phase) ? val : 0;
            1:       d = val;
            2:       d = i;
            default: d = (phase < p && i == (phase + k % p) % p) ? val : 0;
        endcase
        return {(i == p - 1), d[WIDTH-1:0]};
    endfunction

    task automatic add_frames(input int mode, input int period, input int phase, input int val,
                              input int first, input int nfr);
        int p;
        p = eff_p(period);
        for (int k = first; k < first + nfr; k++)
            for (int i = 0; i < p; i++)
                exp_q.push_back(model_beat(mode, p, phase, val, k, i));
    endtask

    // mismatches between got and exp_q over the first n beats (n<0: whole stream, sizes must match)
    function automatic int stream_diff(input int n, output int first);
        int bad, lim;
        bad   = 0;
        first = -1;
        lim   = (n < 0) ? exp_q.size() : n;
        if (n < 0 && got.size() != exp_q.size()) bad++;
        if (got.size() < lim) bad++;
        for (int i = 0; i < lim && i < got.size(); i++)
            if (got[i] !== exp_q[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        return bad;
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic set_cfg(input int mode, input int period, input int phase, input int val,
                           input int nframes);
        cfg_mode    = mode[1:0];
        cfg_period  = period[PW-1:0];
        cfg_phase   = phase[PW-1:0];
        cfg_val     = val[WIDTH-1:0];
        cfg_nframes = nframes[FRAME_W-1:0];
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done) break;
        end
        timed_out = !done;
    endtask

    // configure, start, optionally poke start mid-run, wait for DONE
    task automatic run_stream(input int mode, input int period, input int phase, input int val,
                              input int nframes, input int pct, input bit poke, output bit timed_out);
        set_cfg(mode, period, phase, val, nframes);
        ready_pct = pct;
        exp_q.delete();
        add_frames(mode, period, phase, val, 0, nframes);
        got.delete();
        pulse_start();
        if (poke) begin
            repeat (6) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        wait_done(20000, timed_out);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        set_cfg(0, 8, 0, 1, 1);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy, done} !== '0)
            $display("FAIL reset_state: got v=%b l=%b d=%0d busy=%b done=%b, required all 0",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy, done);
        else n_pass++;
        #1 rst = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, m_axis_tvalid} !== 3'b000)
            $display("FAIL reset_idle: got busy=%b done=%b v=%b, required 0 0 0", busy, done, m_axis_tvalid);
        else n_pass++;
    endtask

    task automatic test_latency();
        bit to;
        set_cfg(2, 4, 0, 0, 1);
        ready_pct = 100;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, m_axis_tvalid} !== 2'b10)
            $display("FAIL latency_t: got busy=%b v=%b, required busy=1 v=0", busy, m_axis_tvalid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, 1'b0, 16'd0})
            $display("FAIL latency_t1: got v=%b l=%b d=%0d, required v=1 l=0 d=0",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        else n_pass++;
        wait_done(100, to);
        n_checks++;
        if (to !== 1'b0) $display("FAIL latency_done: done never rose, required done=1");
        else n_pass++;
    endtask

    task automatic test_impulse();
        bit to; int bad, first;
        run_stream(0, 64, 49, 1, 4, 100, 1'b0, to);
        n_checks++;
        if (to !== 1'b0) $display("FAIL impulse_timeout: done=%b, required 1", done);
        else n_pass++;
        bad = stream_diff(-1, first);
        n_checks++;
        if (bad !== 0)
            $display("FAIL impulse_stream: %0d mismatches (first at %0d), got %0d beats, required %0d",
                     bad, first, got.size(), exp_q.size());
        else n_pass++;
        n_checks++;
        if ({done, busy, m_axis_tvalid} !== 3'b100)
            $display("FAIL impulse_end: got done=%b busy=%b v=%b, required 1 0 0", done, busy, m_axis_tvalid);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({done, m_axis_tvalid} !== 2'b10)
            $display("FAIL impulse_done_hold: got done=%b v=%b, required 1 0", done, m_axis_tvalid);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit to; int bad, first;
        stall_viol = 0;
        run_stream(0, 64, 49, 1, 4, 50, 1'b0, to);
        n_checks++;
        if (to !== 1'b0) $display("FAIL bp_timeout: done=%b, required 1", done);
        else n_pass++;
        bad = stream_diff(-1, first);
        n_checks++;
        if (bad !== 0)
            $display("FAIL bp_stream: %0d mismatches (first at %0d), got %0d beats, required %0d",
                     bad, first, got.size(), exp_q.size());
        else n_pass++;
        n_checks++;
        if (stall_viol !== 0)
            $display("FAIL bp_stable: %0d stalled beats changed, required 0", stall_viol);
        else n_pass++;
    endtask

    task automatic test_swept();
        bit to; int bad, first;
        run_stream(3, 8, 0, 5, 8, 70, 1'b0, to);
        bad = stream_diff(-1, first);
        n_checks++;
        if (to !== 1'b0 || bad !== 0)
            $display("FAIL swept_stream: timeout=%b, %0d mismatches (first at %0d), required 0/0",
                     to, bad, first);
        else n_pass++;
    endtask

    // ramp, DC, P=1 via period 0 and 1, clamped period, phase past the frame end
    task automatic test_ramp_dc();
        int tbl[6][6] = '{'{2, 16,  0, 0,      2, 1},
                          '{1, 10,  0, 32767,  2, 0},
                          '{0, 0,   0, 3,      5, 0},
                          '{3, 1,   0, 9,      4, 0},
                          '{2, 100, 0, 0,      1, 0},
                          '{0, 12,  40, 77,    2, 0}};
        bit to; int bad, first;
        for (int t = 0; t < 6; t++) begin
            stall_viol = 0;
            run_stream(tbl[t][0], tbl[t][1], tbl[t][2], tbl[t][3], tbl[t][4], 60, tbl[t][5] != 0, to);
            bad = stream_diff(-1, first);
            n_checks++;
            if (to !== 1'b0 || bad !== 0 || stall_viol !== 0)
                $display("FAIL table_%0d: timeout=%b mismatches=%0d first=%0d stall=%0d, required 0/0/-/0",
                         t, to, bad, first, stall_viol);
            else n_pass++;
        end
    endtask

    task automatic test_midframe_cfg();
        bit to; int bad, first;
        set_cfg(0, 32, 10, 7, 2);
        ready_pct = 100;
        exp_q.delete();
        add_frames(0, 32, 10, 7, 0, 1);
        add_frames(0, 32, 20, 7, 1, 1);
        got.delete();
        pulse_start();
        for (int c = 0; c < 200 && got.size() < 5; c++) @(negedge clk);
        @(posedge clk); #1 cfg_phase = PW'(20);
        wait_done(500, to);
        bad = stream_diff(-1, first);
        n_checks++;
        if (to !== 1'b0 || bad !== 0)
            $display("FAIL midframe_cfg: timeout=%b %0d mismatches (first at %0d), required 0/0",
                     to, bad, first);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        bit to; int bad, first;
        set_cfg(0, 32, 3, 9, 0);
        ready_pct = 100;
        exp_q.delete();
        add_frames(0, 32, 3, 9, 0, 2);
        got.delete();
        pulse_start();
        for (int c = 0; c < 500 && got.size() < 62; c++) @(negedge clk);
        #1 rst = 1'b1;
        bad = stream_diff(62, first);
        n_checks++;
        if (bad !== 0)
            $display("FAIL rstmid_prefix: %0d mismatches (first at %0d), got %0d beats, required 0",
                     bad, first, got.size());
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy, done} !== '0)
            $display("FAIL rstmid_outputs: got v=%b l=%b d=%0d busy=%b done=%b, required all 0",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy, done);
        else n_pass++;
        #1 rst = 1'b0;
        run_stream(0, 32, 3, 9, 1, 100, 1'b0, to);
        bad = stream_diff(-1, first);
        n_checks++;
        if (to !== 1'b0 || bad !== 0)
            $display("FAIL rstmid_restart: timeout=%b %0d mismatches (first at %0d), required 0/0",
                     to, bad, first);
        else n_pass++;
    endtask

    task automatic test_random();
        bit to; int bad, first, mode, period, phase, val, nfr, pct;
        for (int it = 0; it < 8; it++) begin
            mode   = $urandom_range(3);
            period = $urandom_range(70);
            phase  = $urandom_range(70);
            val    = $urandom_range(65535);
            nfr    = $urandom_range(1, 3);
            pct    = $urandom_range(30, 100);
            stall_viol = 0;
            run_stream(mode, period, phase, val, nfr, pct, 1'b0, to);
            bad = stream_diff(-1, first);
            n_checks++;
            if (to !== 1'b0 || bad !== 0 || stall_viol !== 0)
                $display("FAIL random_%0d (m=%0d P=%0d ph=%0d n=%0d): timeout=%b mismatches=%0d first=%0d stall=%0d, required 0",
                         it, mode, period, phase, nfr, to, bad, first, stall_viol);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_impulse();
        test_backpressure();
        test_swept();
        test_ramp_dc();
        test_midframe_cfg();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
